// File: rtl/arb21_8bit_pkg.sv
// Shared encodings for the two-requester round-robin arbiter.
// Imported by the arbiter top and its testbench.
package arb21_8bit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb21_8bit_mux.sv
// Existing 8-bit 2:1 datapath mux; S=0 passes A, S=1 passes B.
module mux21_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       S,
  output logic [7:0] Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/arb21_8bit.sv
// Round-robin arbiter sharing one registered 8-bit output stage between
// two valid/ready requesters, with a per-owner burst limit under contention.
module arb21_8bit
  import arb21_8bit_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A_valid,
  input  logic [7:0] A,
  output logic       A_ready,
  input  logic       B_valid,
  input  logic [7:0] B,
  output logic       B_ready,
  output logic       Y_valid,
  output logic [7:0] Y,
  input  logic       Y_ready,
  output logic       S
);

  localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       g;
  logic       load;
  logic       accept;
  logic [7:0] mux_y;

  assign Y_valid = (state == ST_HOLD);
  assign load    = !Y_valid || Y_ready;

  // Under contention the owner keeps the channel until cnt reaches the switch point.
  always_comb begin
    g = S;
    if (A_valid && !B_valid)
      g = SEL_A;
    else if (B_valid && !A_valid)
      g = SEL_B;
    else if (A_valid && B_valid)
      g = (cnt == CNT_MAX) ? ~S : S;
  end

  // Readies are held low during reset so no requester believes a beat was taken.
  assign accept  = !rst && load && (A_valid || B_valid);
  assign A_ready = !rst && load && A_valid && (g == SEL_A);
  assign B_ready = !rst && load && B_valid && (g == SEL_B);

  mux21_8bit u_mux (
    .A (A),
    .B (B),
    .S (g),
    .Y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      Y     <= 8'h00;
      S     <= SEL_A;
      cnt   <= 4'd0;
    end else if (accept) begin
      state <= ST_HOLD;
      Y     <= mux_y;
      S     <= g;
      if (g == S)
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
      else
        cnt <= 4'd0;
    end else if (load) begin
      state <= ST_IDLE;
    end
  end

endmodule
